msf_low_time_scanner: RTL and testbench

Controller and arbiter for the read port of the per-second carrier-amplitude BRAM. On each second tick it runs a pipelined scan of entries 0..last_addr, finds the minimum sample, and publishes low_time (index scaled to carrier-count units) for the carrier timing counter. Between scans it shares the same read port with a host/PS single-word read requester.

---
 rtl/msf_low_time_scanner_pkg.sv | 21 ++
 rtl/msf_low_time_scanner_min_tracker.sv | 77 +++++++
 rtl/msf_low_time_scanner.sv | 232 +++++++++++++++++++++++
 tb/tb_msf_low_time_scanner.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/msf_low_time_scanner_pkg.sv
// Shared definitions for the MSF second-BRAM low-time scanner.
// Holds the controller state encoding and the default widths. The writer
// decimation and the low-time scaling share one constant, so they cannot
// drift apart.
package msf_pkg;

    localparam int MSF_ADDR_WIDTH   = 10;
    localparam int MSF_DATA_WIDTH   = 16;
    localparam int MSF_LOW_WIDTH    = 17;
    localparam int MSF_READ_LATENCY = 2;
    localparam int MSF_DECIM_SHIFT  = 10;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_SCAN_ISSUE = 3'd1,
        ST_SCAN_DRAIN = 3'd2,
        ST_PUBLISH    = 3'd3,
        ST_HOST_WAIT  = 3'd4
    } msf_state_e;

endpackage

// File: rtl/msf_low_time_scanner_min_tracker.sv
// Tag pipeline plus running-minimum compare for the second-BRAM scan.
// Ports:
//   clk, resetn      clock, async active-low reset
//   clear            scan start: empties the tag pipe, min=all-ones, addr=0
//   push, push_addr  a scan read is being sampled by the BRAM this edge
//   rdata            BRAM read data, aligned with the last tag stage
//   min_value        running minimum sample
//   min_addr         address of the running minimum (lowest on ties)
//   done             no scan read is still in flight
module msf_min_tracker
    import msf_pkg::*;
#(
    parameter int ADDR_WIDTH   = MSF_ADDR_WIDTH,
    parameter int DATA_WIDTH   = MSF_DATA_WIDTH,
    parameter int READ_LATENCY = MSF_READ_LATENCY
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  clear,
    input  logic                  push,
    input  logic [ADDR_WIDTH-1:0] push_addr,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic [DATA_WIDTH-1:0] min_value,
    output logic [ADDR_WIDTH-1:0] min_addr,
    output logic                  done
);

    logic [READ_LATENCY-1:0] tag_v_r;
    logic [ADDR_WIDTH-1:0]   tag_a_r [READ_LATENCY];
    logic [DATA_WIDTH-1:0]   min_r;
    logic [ADDR_WIDTH-1:0]   min_addr_r;
    logic                    hit_s;

    // Last tag stage lines up with the returning rdata. Strict less-than
    // means an equal sample never displaces an earlier (lower) address.
    assign hit_s = tag_v_r[READ_LATENCY-1] && (rdata < min_r);

    // Tag shift register: one stage per cycle of BRAM read latency.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tag_v_r <= '0;
            for (int i = 0; i < READ_LATENCY; i++) tag_a_r[i] <= '0;
        end else if (clear) begin
            tag_v_r <= '0;
            for (int i = 0; i < READ_LATENCY; i++) tag_a_r[i] <= '0;
        end else begin
            tag_v_r[0] <= push;
            tag_a_r[0] <= push_addr;
            for (int i = 1; i < READ_LATENCY; i++) begin
                tag_v_r[i] <= tag_v_r[i-1];
                tag_a_r[i] <= tag_a_r[i-1];
            end
        end
    end

    // Running minimum and its address.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            min_r      <= '1;
            min_addr_r <= '0;
        end else if (clear) begin
            min_r      <= '1;
            min_addr_r <= '0;
        end else if (hit_s) begin
            min_r      <= rdata;
            min_addr_r <= tag_a_r[READ_LATENCY-1];
        end else begin
            min_r      <= min_r;
            min_addr_r <= min_addr_r;
        end
    end

    assign min_value = min_r;
    assign min_addr  = min_addr_r;
    assign done      = ~|tag_v_r;

endmodule

// File: rtl/msf_low_time_scanner.sv
// Read-port controller/arbiter for the per-second carrier-amplitude BRAM.
// On sec_tick it scans addresses 0..last_addr, finds the minimum sample and
// publishes low_time = min_addr << LOW_SHIFT. While idle it serves single
// host reads on the same port; a scan start wins over a pending host read.
// Ports:
//   clk, resetn               clock, async active-low reset
//   sec_tick, last_addr       scan trigger and highest address to scan
//   bram_en/addr/rdata        shared BRAM read port
//   host_req/addr/ack/rdata   host single-word read handshake
//   low_time, low_time_valid  published minimum position and strobe
//   min_value                 minimum sample of the last scan
//   scan_busy                 scan in progress (start through publish)
//   overrun, overrun_clr      sticky "tick while busy" flag and its clear
module msf_low_time_scanner
    import msf_pkg::*;
#(
    parameter int ADDR_WIDTH   = MSF_ADDR_WIDTH,
    parameter int DATA_WIDTH   = MSF_DATA_WIDTH,
    parameter int READ_LATENCY = MSF_READ_LATENCY,
    parameter int LOW_SHIFT    = MSF_DECIM_SHIFT,
    parameter int LOW_WIDTH    = MSF_LOW_WIDTH
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  sec_tick,
    input  logic [ADDR_WIDTH-1:0] last_addr,
    output logic                  bram_en,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    input  logic [DATA_WIDTH-1:0] bram_rdata,
    input  logic                  host_req,
    input  logic [ADDR_WIDTH-1:0] host_addr,
    output logic                  host_ack,
    output logic [DATA_WIDTH-1:0] host_rdata,
    output logic [LOW_WIDTH-1:0]  low_time,
    output logic                  low_time_valid,
    output logic [DATA_WIDTH-1:0] min_value,
    output logic                  scan_busy,
    output logic                  overrun,
    input  logic                  overrun_clr
);

    localparam int         SHIFT_WIDTH = ADDR_WIDTH + LOW_SHIFT;
    localparam logic [2:0] LAT_CODE    = 3'(READ_LATENCY);

    msf_state_e             state_r, state_s;
    logic [ADDR_WIDTH-1:0]  last_r, last_s;
    logic [2:0]             wait_cnt_r, wait_cnt_s;
    logic                   bram_en_r, bram_en_s;
    logic [ADDR_WIDTH-1:0]  bram_addr_r, bram_addr_s;
    logic                   host_ack_r;
    logic [DATA_WIDTH-1:0]  host_rdata_r;
    logic [LOW_WIDTH-1:0]   low_time_r;
    logic                   low_time_valid_r;
    logic [DATA_WIDTH-1:0]  min_value_r;
    logic                   scan_busy_r;
    logic                   overrun_r;

    logic                   scan_start_s, publish_s, host_cap_s, push_s, tick_drop_s;
    logic [DATA_WIDTH-1:0]  trk_min_s;
    logic [ADDR_WIDTH-1:0]  trk_min_addr_s;
    logic                   trk_done_s;
    logic [SHIFT_WIDTH-1:0] shifted_s;

    // A scan read is in flight when the registered enable is out during issue.
    assign push_s      = bram_en_r & (state_r == ST_SCAN_ISSUE);
    assign tick_drop_s = sec_tick & (state_r != ST_IDLE);
    assign shifted_s   = SHIFT_WIDTH'(trk_min_addr_s) << LOW_SHIFT;

    msf_min_tracker #(
        .ADDR_WIDTH   (ADDR_WIDTH),
        .DATA_WIDTH   (DATA_WIDTH),
        .READ_LATENCY (READ_LATENCY)
    ) u_min_tracker (
        .clk       (clk),
        .resetn    (resetn),
        .clear     (scan_start_s),
        .push      (push_s),
        .push_addr (bram_addr_r),
        .rdata     (bram_rdata),
        .min_value (trk_min_s),
        .min_addr  (trk_min_addr_s),
        .done      (trk_done_s)
    );

    // Next-state and next read-port values; the port is driven from registers,
    // so each branch decides what the BRAM sees in the following cycle.
    always_comb begin
        state_s      = state_r;
        last_s       = last_r;
        wait_cnt_s   = wait_cnt_r;
        bram_en_s    = 1'b0;
        bram_addr_s  = bram_addr_r;
        scan_start_s = 1'b0;
        publish_s    = 1'b0;
        host_cap_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (sec_tick) begin
                    state_s      = ST_SCAN_ISSUE;
                    last_s       = last_addr;
                    bram_en_s    = 1'b1;
                    bram_addr_s  = '0;
                    scan_start_s = 1'b1;
                end else if (host_req) begin
                    state_s     = ST_HOST_WAIT;
                    bram_en_s   = 1'b1;
                    bram_addr_s = host_addr;
                    wait_cnt_s  = 3'd0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SCAN_ISSUE: begin
                if (bram_addr_r == last_r) begin
                    state_s = ST_SCAN_DRAIN;
                end else begin
                    bram_en_s   = 1'b1;
                    bram_addr_s = bram_addr_r + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
                end
            end
            ST_SCAN_DRAIN: begin
                if (trk_done_s) begin
                    state_s   = ST_PUBLISH;
                    publish_s = 1'b1;
                end else begin
                    state_s = ST_SCAN_DRAIN;
                end
            end
            ST_PUBLISH: begin
                state_s = ST_IDLE;
            end
            ST_HOST_WAIT: begin
                // Enable went out the cycle after entry, so data is ready
                // once the counter reaches the read latency.
                if (wait_cnt_r == LAT_CODE) begin
                    state_s    = ST_IDLE;
                    host_cap_s = 1'b1;
                end else begin
                    wait_cnt_s = wait_cnt_r + 3'd1;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // FSM state, sampled scan bound, host wait counter and read port.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r     <= ST_IDLE;
            last_r      <= '0;
            wait_cnt_r  <= 3'd0;
            bram_en_r   <= 1'b0;
            bram_addr_r <= '0;
        end else begin
            state_r     <= state_s;
            last_r      <= last_s;
            wait_cnt_r  <= wait_cnt_s;
            bram_en_r   <= bram_en_s;
            bram_addr_r <= bram_addr_s;
        end
    end

    // Host read capture and acknowledge pulse.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            host_ack_r   <= 1'b0;
            host_rdata_r <= '0;
        end else if (host_cap_s) begin
            host_ack_r   <= 1'b1;
            host_rdata_r <= bram_rdata;
        end else begin
            host_ack_r   <= 1'b0;
            host_rdata_r <= host_rdata_r;
        end
    end

    // Publish registers: low_time/min_value hold between scans.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            low_time_valid_r <= 1'b0;
            low_time_r       <= '0;
            min_value_r      <= '0;
        end else if (publish_s) begin
            low_time_valid_r <= 1'b1;
            low_time_r       <= LOW_WIDTH'(shifted_s);
            min_value_r      <= trk_min_s;
        end else begin
            low_time_valid_r <= 1'b0;
            low_time_r       <= low_time_r;
            min_value_r      <= min_value_r;
        end
    end

    // Busy flag spans scan start through the publish cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            scan_busy_r <= 1'b0;
        end else if (scan_start_s) begin
            scan_busy_r <= 1'b1;
        end else if (state_r == ST_PUBLISH) begin
            scan_busy_r <= 1'b0;
        end else begin
            scan_busy_r <= scan_busy_r;
        end
    end

    // Sticky overrun; the clear takes precedence over a coincident event.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            overrun_r <= 1'b0;
        end else if (overrun_clr) begin
            overrun_r <= 1'b0;
        end else if (tick_drop_s) begin
            overrun_r <= 1'b1;
        end else begin
            overrun_r <= overrun_r;
        end
    end

    assign bram_en        = bram_en_r;
    assign bram_addr      = bram_addr_r;
    assign host_ack       = host_ack_r;
    assign host_rdata     = host_rdata_r;
    assign low_time       = low_time_r;
    assign low_time_valid = low_time_valid_r;
    assign min_value      = min_value_r;
    assign scan_busy      = scan_busy_r;
    assign overrun        = overrun_r;

endmodule

// File: tb/tb_msf_low_time_scanner.sv
`timescale 1ns/1ps
// Directed bench: three scanner builds (A: latency 2 / shift 10,
// B: latency 4 / shift 16, C: latency 1 / shift 10) read one shared memory.
module tb_msf_low_time_scanner;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        resetn;
    logic        tick_a, tick_b, tick_c;
    logic [9:0]  last_addr;
    logic        host_req;
    logic [9:0]  host_addr;
    logic        overrun_clr;
    logic        en_a, en_b, en_c;
    logic [9:0]  addr_a, addr_b, addr_c;
    logic [15:0] rd_a, rd_b, rd_c;
    logic        ack_a, ack_b, ack_c;
    logic [15:0] hrd_a, hrd_b, hrd_c;
    logic [16:0] lt_a, lt_b, lt_c;
    logic        ltv_a, ltv_b, ltv_c;
    logic [15:0] mv_a, mv_b, mv_c;
    logic        busy_a, busy_b, busy_c;
    logic        ovr_a, ovr_b, ovr_c;

    logic [15:0] mem [0:1023];
    int checks = 0;
    int failures = 0;

    // BRAM models: data for an enable sampled at edge E is valid after E+L-1.
    bit   [1:0] pv_a;  logic [9:0] pa_a [0:1];
    bit   [3:0] pv_b;  logic [9:0] pa_b [0:3];
    bit         pv_c;  logic [9:0] pa_c;
    always @(posedge clk) begin
        pv_a <= {pv_a[0], en_a}; pa_a[0] <= addr_a; pa_a[1] <= pa_a[0];
        pv_b <= {pv_b[2:0], en_b}; pa_b[0] <= addr_b;
        pa_b[1] <= pa_b[0]; pa_b[2] <= pa_b[1]; pa_b[3] <= pa_b[2];
        pv_c <= en_c; pa_c <= addr_c;
    end
    assign rd_a = pv_a[1] ? mem[pa_a[1]] : 16'h0000;
    assign rd_b = pv_b[3] ? mem[pa_b[3]] : 16'h0000;
    assign rd_c = pv_c    ? mem[pa_c]    : 16'h0000;

    msf_low_time_scanner #(.READ_LATENCY(2), .LOW_SHIFT(10)) dut_a (
        .clk(clk), .resetn(resetn), .sec_tick(tick_a), .last_addr(last_addr),
        .bram_en(en_a), .bram_addr(addr_a), .bram_rdata(rd_a),
        .host_req(host_req), .host_addr(host_addr), .host_ack(ack_a), .host_rdata(hrd_a),
        .low_time(lt_a), .low_time_valid(ltv_a), .min_value(mv_a),
        .scan_busy(busy_a), .overrun(ovr_a), .overrun_clr(overrun_clr));

    msf_low_time_scanner #(.READ_LATENCY(4), .LOW_SHIFT(16)) dut_b (
        .clk(clk), .resetn(resetn), .sec_tick(tick_b), .last_addr(last_addr),
        .bram_en(en_b), .bram_addr(addr_b), .bram_rdata(rd_b),
        .host_req(1'b0), .host_addr(10'd0), .host_ack(ack_b), .host_rdata(hrd_b),
        .low_time(lt_b), .low_time_valid(ltv_b), .min_value(mv_b),
        .scan_busy(busy_b), .overrun(ovr_b), .overrun_clr(1'b0));

    msf_low_time_scanner #(.READ_LATENCY(1), .LOW_SHIFT(10)) dut_c (
        .clk(clk), .resetn(resetn), .sec_tick(tick_c), .last_addr(last_addr),
        .bram_en(en_c), .bram_addr(addr_c), .bram_rdata(rd_c),
        .host_req(1'b0), .host_addr(10'd0), .host_ack(ack_c), .host_rdata(hrd_c),
        .low_time(lt_c), .low_time_valid(ltv_c), .min_value(mv_c),
        .scan_busy(busy_c), .overrun(ovr_c), .overrun_clr(1'b0));

    int lat_a, lat_b, lat_c, cnt_a, cnt_b, cnt_c, en_cnt_a, en_first_a, en_last_a;

    task automatic load_scan_pattern();
        for (int i = 0; i < 1024; i++) mem[i] = (i < 50) ? 16'(100 - i) : 16'd200;
        mem[37] = 16'd5;
        mem[76] = 16'd1;  // just beyond the scan range; must never be seen
    endtask

    // Tick all three builds together; index j = observation after edge E_j,
    // where E_0 is the edge that samples the tick.
    task automatic scan_all(input logic [9:0] last);
        last_addr = last;
        lat_a = 0; lat_b = 0; lat_c = 0; cnt_a = 0; cnt_b = 0; cnt_c = 0;
        en_cnt_a = 0; en_first_a = -1; en_last_a = -1;
        tick_a = 1'b1; tick_b = 1'b1; tick_c = 1'b1;
        @(posedge clk); #1;
        tick_a = 1'b0; tick_b = 1'b0; tick_c = 1'b0;
        for (int j = 0; j <= int'(last) + 12; j++) begin
            @(negedge clk);
            if (ltv_a) begin cnt_a++; if (lat_a == 0) lat_a = j; end
            if (ltv_b) begin cnt_b++; if (lat_b == 0) lat_b = j; end
            if (ltv_c) begin cnt_c++; if (lat_c == 0) lat_c = j; end
            if (en_a) begin en_cnt_a++; if (en_first_a < 0) en_first_a = j; en_last_a = j; end
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0; tick_a = 1'b0; tick_b = 1'b0; tick_c = 1'b0;
        last_addr = 10'd0; host_req = 1'b0; host_addr = 10'd0; overrun_clr = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if ({en_a, ack_a, ltv_a, busy_a, ovr_a} !== 5'b0) begin
            failures++; $display("FAIL reset_flags got=%b exp=00000", {en_a, ack_a, ltv_a, busy_a, ovr_a}); end
        checks++; if ({lt_a, mv_a, hrd_a, addr_a} !== 59'd0) begin
            failures++; $display("FAIL reset_values got=%0h exp=0", {lt_a, mv_a, hrd_a, addr_a}); end
        resetn = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_scan();
        load_scan_pattern();
        scan_all(10'd75);
        checks++; if (lat_a !== 79) begin failures++; $display("FAIL scan_lat_a got=%0d exp=79", lat_a); end
        checks++; if (cnt_a !== 1) begin failures++; $display("FAIL scan_pulses_a got=%0d exp=1", cnt_a); end
        checks++; if (mv_a !== 16'd5) begin failures++; $display("FAIL scan_min_a got=%0d exp=5", mv_a); end
        checks++; if (lt_a !== 17'd37888) begin failures++; $display("FAIL scan_low_a got=%0d exp=37888", lt_a); end
        checks++; if (en_cnt_a !== 76 || en_first_a !== 0 || en_last_a !== 75) begin failures++;
            $display("FAIL scan_en_a got=%0d/%0d/%0d exp=76/0/75", en_cnt_a, en_first_a, en_last_a); end
        checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL scan_busy_end got=%b exp=0", busy_a); end
        checks++; if (lat_b !== 81 || cnt_b !== 1) begin failures++;
            $display("FAIL scan_lat_b got=%0d/%0d exp=81/1", lat_b, cnt_b); end
        checks++; if (lt_b !== 17'd65536 || mv_b !== 16'd5) begin failures++;
            $display("FAIL scan_res_b got=%0d/%0d exp=65536/5", lt_b, mv_b); end
        checks++; if (lat_c !== 78 || cnt_c !== 1) begin failures++;
            $display("FAIL scan_lat_c got=%0d/%0d exp=78/1", lat_c, cnt_c); end
        checks++; if (lt_c !== 17'd37888 || mv_c !== 16'd5) begin failures++;
            $display("FAIL scan_res_c got=%0d/%0d exp=37888/5", lt_c, mv_c); end
    endtask

    task automatic test_tie();
        for (int i = 0; i < 1024; i++) mem[i] = 16'd500;
        mem[3] = 16'd0; mem[9] = 16'd0;
        scan_all(10'd9);
        checks++; if (lat_a !== 13) begin failures++; $display("FAIL tie_lat_a got=%0d exp=13", lat_a); end
        checks++; if (lt_a !== 17'd3072 || mv_a !== 16'd0) begin failures++;
            $display("FAIL tie_res_a got=%0d/%0d exp=3072/0", lt_a, mv_a); end
        checks++; if (lt_b !== 17'd65536 || mv_b !== 16'd0) begin failures++;
            $display("FAIL tie_trunc_b got=%0d/%0d exp=65536/0", lt_b, mv_b); end
        // single-read scan: address 0 only
        mem[0] = 16'd77;
        scan_all(10'd0);
        checks++; if (lat_a !== 4 || lt_a !== 17'd0 || mv_a !== 16'd77) begin failures++;
            $display("FAIL one_read_a got=%0d/%0d/%0d exp=4/0/77", lat_a, lt_a, mv_a); end
    endtask

    task automatic test_arbitration();
        int pub_j, ack_j, ack_cnt, en_in_issue;
        logic [15:0] ack_data;
        load_scan_pattern();
        last_addr = 10'd75;
        pub_j = -1; ack_j = -1; ack_cnt = 0; en_in_issue = 0; ack_data = 16'd0;
        tick_a = 1'b1; host_req = 1'b1; host_addr = 10'd5;
        @(posedge clk); #1;
        tick_a = 1'b0;
        for (int j = 0; j <= 120; j++) begin
            @(negedge clk);
            if (ltv_a && pub_j < 0) pub_j = j;
            if (ack_a) begin ack_cnt++; ack_j = j; ack_data = hrd_a; host_req = 1'b0; end
            if (j <= 75 && en_a && addr_a == 10'(j)) en_in_issue++;
        end
        host_req = 1'b0;
        checks++; if (pub_j !== 79) begin failures++; $display("FAIL arb_pub got=%0d exp=79", pub_j); end
        checks++; if (ack_j !== 84 || ack_cnt !== 1) begin failures++;
            $display("FAIL arb_ack got=%0d/%0d exp=84/1", ack_j, ack_cnt); end
        checks++; if (ack_data !== 16'd95) begin failures++; $display("FAIL arb_rdata got=%0d exp=95", ack_data); end
        checks++; if (en_in_issue !== 76) begin failures++; $display("FAIL arb_en_gap got=%0d exp=76", en_in_issue); end
    endtask

    task automatic test_overrun();
        int pubs;
        pubs = 0;
        last_addr = 10'd75;
        tick_a = 1'b1;
        @(posedge clk); #1;
        tick_a = 1'b0;
        for (int j = 0; j <= 120; j++) begin
            @(negedge clk);
            if (ltv_a) pubs++;
            tick_a = (j == 10);
        end
        tick_a = 1'b0;
        checks++; if (ovr_a !== 1'b1) begin failures++; $display("FAIL ovr_set got=%b exp=1", ovr_a); end
        checks++; if (pubs !== 1) begin failures++; $display("FAIL ovr_pubs got=%0d exp=1", pubs); end
        overrun_clr = 1'b1;
        @(negedge clk);
        overrun_clr = 1'b0;
        checks++; if (ovr_a !== 1'b0) begin failures++; $display("FAIL ovr_clr got=%b exp=0", ovr_a); end
        tick_a = 1'b1;
        @(posedge clk); #1;
        tick_a = 1'b0;
        for (int j = 0; j <= 100; j++) begin
            @(negedge clk);
            tick_a = (j == 5);
            overrun_clr = (j == 5);
        end
        tick_a = 1'b0; overrun_clr = 1'b0;
        checks++; if (ovr_a !== 1'b0) begin failures++; $display("FAIL ovr_clr_wins got=%b exp=0", ovr_a); end
    endtask

    task automatic test_reset_midscan();
        int pubs;
        pubs = 0;
        last_addr = 10'd75;
        tick_a = 1'b1;
        @(posedge clk); #1;
        tick_a = 1'b0;
        for (int j = 0; j < 20; j++) @(negedge clk);
        resetn = 1'b0;
        #1;
        checks++; if ({en_a, ltv_a, busy_a, ovr_a, ack_a} !== 5'b0) begin failures++;
            $display("FAIL midrst_flags got=%b exp=00000", {en_a, ltv_a, busy_a, ovr_a, ack_a}); end
        checks++; if (lt_a !== 17'd0 || mv_a !== 16'd0 || addr_a !== 10'd0) begin failures++;
            $display("FAIL midrst_values got=%0d/%0d/%0d exp=0/0/0", lt_a, mv_a, addr_a); end
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        for (int j = 0; j < 150; j++) begin
            @(negedge clk);
            if (ltv_a) pubs++;
        end
        checks++; if (pubs !== 0) begin failures++; $display("FAIL midrst_nopub got=%0d exp=0", pubs); end
        scan_all(10'd75);
        checks++; if (lat_a !== 79 || lt_a !== 17'd37888 || mv_a !== 16'd5) begin failures++;
            $display("FAIL midrst_rescan got=%0d/%0d/%0d exp=79/37888/5", lat_a, lt_a, mv_a); end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_tie();
        test_arbitration();
        test_overrun();
        test_reset_midscan();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
